// File: rtl/dbg_mem_loader.sv
// Debug word loader: assembles 32-bit words from debounced hex-nibble presses and
// writes each completed word to a memory port over a req/ack handshake.
module dbg_mem_loader #(
  parameter logic [19:0] DB_CYCLES = 20'd1000000,
  parameter int          ADDR_W    = 6,
  parameter int          DEPTH     = 48
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        nib_i,
  input  logic              btn_i,
  input  logic              clr_i,
  input  logic              addr_ld_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  output logic              wr_req_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  input  logic              wr_ack_i,
  output logic [3:0]        nib_cnt_o,
  output logic              busy_o,
  output logic [63:0]       disp_data_o
);

  typedef enum logic {COLLECT, WAIT_ACK} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // ---------------- button synchroniser and debouncer ----------------
  logic        btn_s1, btn_s2;
  logic        btn_db, btn_db_q;
  logic [19:0] db_cnt;
  logic        press;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_s1   <= btn_i;
      btn_s2   <= btn_s1;
      btn_db_q <= btn_db;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_CYCLES - 20'd1) begin
        btn_db <= ~btn_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 20'd1;
      end
    end
  end

  // Only the rising edge of the debounced level is an event; release is silent.
  assign press = btn_db & ~btn_db_q;

  // ---------------- collector / handshake FSM ----------------
  state_t            state, state_n;
  logic [31:0]       word, word_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [3:0]        nib_cnt, nib_cnt_n;
  logic              wr_req, wr_req_n;
  logic [31:0]       wr_data, wr_data_n;
  logic              busy, busy_n;
  logic [63:0]       disp;
  logic [ADDR_W-1:0] ld_addr;

  assign ld_addr = (start_addr_i > LAST_ADDR) ? LAST_ADDR : start_addr_i;

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_n   = state;
    word_n    = word;
    addr_n    = addr;
    nib_cnt_n = nib_cnt;
    wr_req_n  = wr_req;
    wr_data_n = wr_data;
    busy_n    = busy;
    case (state)
      COLLECT: begin
        if (clr_i) begin
          word_n    = '0;
          nib_cnt_n = '0;
        end else if (addr_ld_i && nib_cnt == 4'd0) begin
          addr_n = ld_addr;
        end else if (press) begin
          word_n    = {word[27:0], nib_i};
          nib_cnt_n = nib_cnt + 4'd1;
          if (nib_cnt == 4'd7) begin
            wr_data_n = {word[27:0], nib_i};
            wr_req_n  = 1'b1;
            busy_n    = 1'b1;
            state_n   = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        // Inputs other than the ack are dropped here; the request stays frozen.
        if (wr_req && wr_ack_i) begin
          wr_req_n  = 1'b0;
          busy_n    = 1'b0;
          word_n    = '0;
          nib_cnt_n = '0;
          state_n   = COLLECT;
          addr_n    = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= COLLECT;
      word    <= '0;
      addr    <= '0;
      nib_cnt <= '0;
      wr_req  <= 1'b0;
      wr_data <= '0;
      busy    <= 1'b0;
      disp    <= '0;
    end else begin
      state   <= state_n;
      word    <= word_n;
      addr    <= addr_n;
      nib_cnt <= nib_cnt_n;
      wr_req  <= wr_req_n;
      wr_data <= wr_data_n;
      busy    <= busy_n;
      disp    <= {{(32 - ADDR_W){1'b0}}, addr, word};
    end
  end

  assign wr_req_o    = wr_req;
  assign wr_addr_o   = addr;
  assign wr_data_o   = wr_data;
  assign nib_cnt_o   = nib_cnt;
  assign busy_o      = busy;
  assign disp_data_o = disp;

endmodule

// File: tb/tb_dbg_mem_loader.sv
// Directed + randomized bench for dbg_mem_loader against a word/address model
// built from the operator-level rules (nibbles shift in MSB first, address wraps).
module tb_dbg_mem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 48;

  logic              clk = 1'b0;
  logic              rstn;
  logic [3:0]        nib_i;
  logic              btn_i;
  logic              clr_i;
  logic              addr_ld_i;
  logic [ADDR_W-1:0] start_addr_i;
  logic              wr_req_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [31:0]       wr_data_o;
  logic              wr_ack_i;
  logic [3:0]        nib_cnt_o;
  logic              busy_o;
  logic [63:0]       disp_data_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0]       m_word;
  logic [ADDR_W-1:0] m_addr;
  int                m_cnt;

  dbg_mem_loader #(.DB_CYCLES(20'd4), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .nib_i        (nib_i),
    .btn_i        (btn_i),
    .clr_i        (clr_i),
    .addr_ld_i    (addr_ld_i),
    .start_addr_i (start_addr_i),
    .wr_req_o     (wr_req_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .wr_ack_i     (wr_ack_i),
    .nib_cnt_o    (nib_cnt_o),
    .busy_o       (busy_o),
    .disp_data_o  (disp_data_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_disp();
    return {32'(m_addr), m_word};
  endfunction

  task automatic model_nib(input logic [3:0] n);
    m_word = m_word * 32'd16 + 32'(n);
    m_cnt++;
  endtask

  task automatic model_clear();
    m_word = '0;
    m_cnt  = 0;
  endtask

  task automatic press(input logic [3:0] n);
    nib_i = n;
    btn_i = 1'b1;
    step(8);
    btn_i = 1'b0;
    step(8);
  endtask

  task automatic check_collect(input string tag);
    check({tag, "_cnt"},  64'(nib_cnt_o), 64'(m_cnt));
    check({tag, "_addr"}, 64'(wr_addr_o), 64'(m_addr));
    check({tag, "_disp"}, disp_data_o, exp_disp());
    check({tag, "_req"},  64'(wr_req_o), 64'd0);
  endtask

  // Enter all eight nibbles of w; returns with req freshly raised and btn still high.
  task automatic word_to_req(input logic [31:0] w);
    int lat;
    bit seen;
    for (int i = 7; i >= 1; i--) begin
      press(w[4*i +: 4]);
      model_nib(w[4*i +: 4]);
    end
    check("pre_last_cnt", 64'(nib_cnt_o), 64'd7);
    nib_i = w[3:0];
    btn_i = 1'b1;
    lat   = 0;
    seen  = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step(1);
      lat++;
      if (wr_req_o) seen = 1'b1;
    end
    model_nib(w[3:0]);
    check("req_seen",    64'(seen), 64'd1);
    check("req_latency", 64'(lat), 64'd7);
    check("req_addr",    64'(wr_addr_o), 64'(m_addr));
    check("req_data",    64'(wr_data_o), 64'(m_word));
    check("req_busy",    64'(busy_o), 64'd1);
    check("req_cnt",     64'(nib_cnt_o), 64'd8);
  endtask

  // Keep req for 'hold' visible cycles, then ack for 'ack_len' cycles.
  task automatic ack_after(input int hold, input int ack_len);
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
    a = wr_addr_o;
    d = wr_data_o;
    for (int i = 1; i < hold; i++) begin
      step(1);
      check("hold_req",  64'(wr_req_o), 64'd1);
      check("hold_addr", 64'(wr_addr_o), 64'(a));
      check("hold_data", 64'(wr_data_o), 64'(d));
    end
    wr_ack_i = 1'b1;
    step(1);
    m_addr = (int'(m_addr) == DEPTH - 1) ? '0 : m_addr + 1'b1;
    model_clear();
    check("ack_req",  64'(wr_req_o), 64'd0);
    check("ack_busy", 64'(busy_o), 64'd0);
    check("ack_cnt",  64'(nib_cnt_o), 64'd0);
    check("ack_addr", 64'(wr_addr_o), 64'(m_addr));
    if (ack_len > 1) begin
      step(ack_len - 1);
      check("long_ack_addr", 64'(wr_addr_o), 64'(m_addr));
      check("long_ack_req",  64'(wr_req_o), 64'd0);
    end
    wr_ack_i = 1'b0;
    btn_i    = 1'b0;
    step(8);
    check("post_ack_disp", disp_data_o, exp_disp());
  endtask

  initial begin
    logic [31:0]       w;
    logic [ADDR_W-1:0] a_hold;
    logic [31:0]       d_hold;

    rstn = 1'b0; nib_i = '0; btn_i = 1'b0; clr_i = 1'b0; addr_ld_i = 1'b0;
    start_addr_i = '0; wr_ack_i = 1'b0;
    m_addr = '0;
    model_clear();
    step(2);
    check("rst_req",  64'(wr_req_o), 64'd0);
    check("rst_addr", 64'(wr_addr_o), 64'd0);
    check("rst_data", 64'(wr_data_o), 64'd0);
    check("rst_cnt",  64'(nib_cnt_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_disp", disp_data_o, 64'd0);
    rstn = 1'b1;
    step(2);

    // Single clean press: press pulse lands 6 cycles after rise, count one cycle later.
    nib_i = 4'hA;
    btn_i = 1'b1;
    step(6);
    check("first_cnt_before", 64'(nib_cnt_o), 64'd0);
    step(1);
    check("first_cnt_after", 64'(nib_cnt_o), 64'd1);
    model_nib(4'hA);
    step(1);
    check("first_disp", disp_data_o, 64'h0000_0000_0000_000A);
    btn_i = 1'b0;
    step(8);

    // Bouncing button: toggles every 2 cycles, then settles high.
    nib_i = 4'h5;
    for (int i = 0; i < 5; i++) begin
      btn_i = 1'b1; step(2);
      btn_i = 1'b0; step(2);
    end
    check("bounce_no_accept", 64'(nib_cnt_o), 64'd1);
    btn_i = 1'b1; step(10);
    btn_i = 1'b0; step(8);
    model_nib(4'h5);
    check_collect("bounce");

    // Address load while nibbles are pending is ignored.
    start_addr_i = 6'd9; addr_ld_i = 1'b1; step(2); addr_ld_i = 1'b0; step(1);
    check_collect("ld_pending");

    // Third nibble, then clear coincident with a press.
    press(4'h3);
    model_nib(4'h3);
    check_collect("third");
    clr_i = 1'b1;
    press(4'h7);
    clr_i = 1'b0;
    model_clear();
    check_collect("clr_press");

    // Known word at address 0, ack such that req is high for 3 cycles.
    word_to_req(32'h1234_5678);
    check("known_data", 64'(wr_data_o), 64'h1234_5678);
    ack_after(3, 1);
    check_collect("known_done");

    // Address loads: clamp, plain, then the last address.
    start_addr_i = 6'd60; addr_ld_i = 1'b1; step(1); addr_ld_i = 1'b0; step(1);
    m_addr = 6'(DEPTH - 1);
    check("clamp_addr", 64'(wr_addr_o), 64'(m_addr));
    start_addr_i = 6'd20; addr_ld_i = 1'b1; step(1); addr_ld_i = 1'b0; step(1);
    m_addr = 6'd20;
    check("ld20_addr", 64'(wr_addr_o), 64'(m_addr));
    start_addr_i = 6'd47; addr_ld_i = 1'b1; step(1); addr_ld_i = 1'b0; step(1);
    m_addr = 6'd47;
    check("ld47_addr", 64'(wr_addr_o), 64'd47);
    for (int k = 0; k < 2; k++) begin
      w = $urandom;
      word_to_req(w);
      check("wrap_addr", 64'(wr_addr_o), (k == 0) ? 64'd47 : 64'd0);
      ack_after(int'($urandom_range(1, 4)), 1);
    end

    // Minimum req pulse with ack held high for several cycles.
    w = $urandom;
    word_to_req(w);
    ack_after(1, 4);
    check_collect("long_ack");

    // Press, clear and address load during WAIT_ACK are all dropped.
    w = $urandom;
    word_to_req(w);
    a_hold = wr_addr_o;
    d_hold = wr_data_o;
    btn_i = 1'b0; step(8);
    clr_i = 1'b1; addr_ld_i = 1'b1; start_addr_i = 6'd5;
    press(4'hF);
    clr_i = 1'b0; addr_ld_i = 1'b0;
    check("wait_req",  64'(wr_req_o), 64'd1);
    check("wait_addr", 64'(wr_addr_o), 64'(a_hold));
    check("wait_data", 64'(wr_data_o), 64'(d_hold));
    check("wait_cnt",  64'(nib_cnt_o), 64'd8);
    ack_after(1, 1);
    check_collect("wait_done");

    // Randomized words with random ack latency.
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      word_to_req(w);
      ack_after(int'($urandom_range(1, 5)), int'($urandom_range(1, 3)));
    end
    check_collect("rand_done");

    // Reset mid-handshake: outputs drop asynchronously, no write completes.
    w = $urandom;
    word_to_req(w);
    rstn = 1'b0;
    #1;
    check("arst_req",  64'(wr_req_o), 64'd0);
    check("arst_busy", 64'(busy_o), 64'd0);
    check("arst_data", 64'(wr_data_o), 64'd0);
    check("arst_addr", 64'(wr_addr_o), 64'd0);
    check("arst_disp", disp_data_o, 64'd0);
    btn_i = 1'b0;
    step(2);
    rstn = 1'b1;
    m_addr = '0;
    model_clear();
    step(2);
    check_collect("after_arst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
